// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Key map entry i sits at bits [4*i+3:4*i], with index i = {row, col}.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } kp_state_e;

    localparam logic [3:0]  ROW_IDLE = 4'hF;

    // Rows 0..3 are 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D, written from entry 15 down to entry 0.
    localparam logic [63:0] KEY_MAP  = 64'hDEF0_C987_B654_A321;

endpackage

// File: rtl/keypad_key_decoder.sv
// Maps a captured row pattern and column index to a hex key code.
// valid_single_o is high only when exactly one row line is low.
module keypad_key_decoder
    import keypad_pkg::*;
(
    input  logic [3:0] row_cap_i,
    input  logic [1:0] col_idx_i,
    output logic       valid_single_o,
    output logic [3:0] code_o
);

    logic [1:0] row_idx;
    logic [5:0] map_base;

    always_comb begin
        valid_single_o = 1'b0;
        row_idx        = 2'd0;
        case (row_cap_i)
            4'b1110: begin valid_single_o = 1'b1; row_idx = 2'd0; end
            4'b1101: begin valid_single_o = 1'b1; row_idx = 2'd1; end
            4'b1011: begin valid_single_o = 1'b1; row_idx = 2'd2; end
            4'b0111: begin valid_single_o = 1'b1; row_idx = 2'd3; end
            default: begin valid_single_o = 1'b0; row_idx = 2'd0; end
        endcase
    end

    assign map_base = {row_idx, col_idx_i, 2'b00};
    assign code_o   = KEY_MAP[map_base +: 4];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column dwell scan, press/release debounce.
// Build option KEYPAD_SHIFT_REG_EN adds the 16-bit DataOut digit-entry register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ScanClockCycle       = 50000,
    parameter int ScanCounterWidth     = 16,
    parameter int DebounceCycles       = 500000,
    parameter int DebounceCounterWidth = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic        KeyValid,
    output logic [3:0]  KeyCode,
    output logic        KeyHeld
`ifdef KEYPAD_SHIFT_REG_EN
    ,
    output logic [15:0] DataOut
`endif
);

    localparam logic [ScanCounterWidth-1:0]     SCAN_LAST = ScanCounterWidth'(ScanClockCycle - 1);
    localparam logic [DebounceCounterWidth-1:0] DEB_LAST  = DebounceCounterWidth'(DebounceCycles - 1);

    kp_state_e                       state_q;
    logic [3:0]                      row_meta_q;
    logic [3:0]                      row_sync_q;
    logic [3:0]                      row_cap_q;
    logic [1:0]                      col_idx_q;
    logic [ScanCounterWidth-1:0]     dwell_q;
    logic [DebounceCounterWidth-1:0] deb_q;
    logic                            key_valid_q;
    logic [3:0]                      key_code_q;
    logic                            key_held_q;
    logic                            dec_valid;
    logic [3:0]                      dec_code;
`ifdef KEYPAD_SHIFT_REG_EN
    logic [15:0]                     data_q;
`endif

    // Synchronizer resets to idle so no phantom press is seen right after reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            row_meta_q <= ROW_IDLE;
            row_sync_q <= ROW_IDLE;
        end else begin
            row_meta_q <= Row;
            row_sync_q <= row_meta_q;
        end
    end

    keypad_key_decoder u_decoder (
        .row_cap_i      (row_cap_q),
        .col_idx_i      (col_idx_q),
        .valid_single_o (dec_valid),
        .code_o         (dec_code)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            row_cap_q   <= ROW_IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_SHIFT_REG_EN
            data_q      <= 16'h0000;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == SCAN_LAST) begin
                        dwell_q <= '0;
                        if (row_sync_q == ROW_IDLE) begin
                            col_idx_q <= col_idx_q + 2'd1;
                        end else begin
                            row_cap_q <= row_sync_q;
                            deb_q     <= '0;
                            state_q   <= DEBOUNCE;
                        end
                    end else begin
                        dwell_q <= dwell_q + ScanCounterWidth'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_sync_q != row_cap_q) begin
                        dwell_q <= '0;
                        state_q <= SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        deb_q <= '0;
                        if (dec_valid) begin
                            state_q     <= PRESSED;
                            key_valid_q <= 1'b1;
                            key_code_q  <= dec_code;
`ifdef KEYPAD_SHIFT_REG_EN
                            data_q      <= {data_q[11:0], dec_code};
`endif
                        end else begin
                            // Ghosting / multi-key: wait out the release silently.
                            state_q    <= RELEASE_WAIT;
                            key_held_q <= 1'b1;
                        end
                    end else begin
                        deb_q <= deb_q + DebounceCounterWidth'(1);
                    end
                end
                PRESSED: begin
                    deb_q      <= '0;
                    key_held_q <= 1'b1;
                    state_q    <= RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    if (row_sync_q != ROW_IDLE) begin
                        deb_q <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        deb_q      <= '0;
                        dwell_q    <= '0;
                        col_idx_q  <= col_idx_q + 2'd1;
                        key_held_q <= 1'b0;
                        state_q    <= SCAN;
                    end else begin
                        deb_q <= deb_q + DebounceCounterWidth'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign Col      = ~(4'b0001 << col_idx_q);
    assign KeyValid = key_valid_q;
    assign KeyCode  = key_code_q;
    assign KeyHeld  = key_held_q;
`ifdef KEYPAD_SHIFT_REG_EN
    assign DataOut  = data_q;
`endif

endmodule
